bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 14 +
 rtl/bit_serializer_bit_counter.sv | 34 +++
 rtl/bit_serializer.sv | 109 ++++++++++
 tb/tb_bit_serializer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - FSM state encodings shared with sequence_detector
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } ser_state_e;

    function automatic int ser_cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer_bit_counter.sv
// rtl/bit_serializer_bit_counter.sv - serial bit index counter with terminal-count flag
module bit_counter #(
    parameter int CW   = 3,
    parameter int LAST = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(LAST));

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial shifter; BIT_SERIALIZER_PARITY_EN appends even parity
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             X,
    output logic             X_VALID,
    output logic             DONE
);

    localparam int CW = ser_cnt_width(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             tc;
    logic             xfer;
    logic             cnt_en;

`ifdef BIT_SERIALIZER_PARITY_EN
    logic parity_q, parity_d;
`endif

    // Counter holds at terminal count so it never wraps inside a word.
    bit_counter #(
        .CW   (CW),
        .LAST (WIDTH - 1)
    ) u_bit_counter (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .clr_i  (xfer),
        .en_i   (cnt_en),
        .tc_o   (tc)
    );

    assign xfer   = DIN_VALID && DIN_READY;
    assign cnt_en = (state_q == SHIFT) && !tc;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        X         = 1'b0;
        X_VALID   = 1'b0;
        DONE      = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            SHIFT: begin
                X       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
                X_VALID = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                DONE    = tc;
`endif
                shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, shreg_q[WIDTH-1:1]};
                if (tc) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                X       = parity_q;
                X_VALID = 1'b1;
                DONE    = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        // Readiness depends only on state, so a capture here overrides the shift above.
        if (xfer) begin
            state_d  = SHIFT;
            shreg_d  = DIN;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_d = ^DIN;
`endif
        end
    end

    assign DIN_READY = nRST && ((state_q == IDLE) || DONE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed checks of bit_serializer, MSB-first and LSB-first instances
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int WL = 9;
`else
    localparam int WL = 8;
`endif

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       rdy_m, x_m, xv_m, done_m;
    logic       rdy_l, x_l, xv_l, done_l;
    int         checks = 0;
    int         failures = 0;

    always #5 CLK = ~CLK;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
        .CLK(CLK), .nRST(nRST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(rdy_m), .X(x_m), .X_VALID(xv_m), .DONE(done_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .CLK(CLK), .nRST(nRST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(rdy_l), .X(x_l), .X_VALID(xv_l), .DONE(done_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit lsb);
        if (i >= 8) return ^w;
        return lsb ? w[i] : w[7-i];
    endfunction

    // One isolated word; optionally offers a stray word mid-transfer.
    task automatic run_word(input logic [7:0] w, input bit lsb, input bit pulse);
        logic x, xv, dn, rd;
        DIN = w;
        DIN_VALID = 1'b1;
        check("ready_before", lsb ? rdy_l : rdy_m, 1'b1);
        step();
        DIN_VALID = 1'b0;
        for (int i = 0; i < WL; i++) begin
            x  = lsb ? x_l : x_m;
            xv = lsb ? xv_l : xv_m;
            dn = lsb ? done_l : done_m;
            rd = lsb ? rdy_l : rdy_m;
            check($sformatf("x_%02h_b%0d", w, i), x, exp_bit(w, i, lsb));
            check($sformatf("xv_%02h_b%0d", w, i), xv, 1'b1);
            check($sformatf("done_%02h_b%0d", w, i), dn, (i == WL - 1));
            check($sformatf("rdy_%02h_b%0d", w, i), rd, (i == WL - 1));
            if (pulse && i == 3) begin
                DIN = 8'h5A;
                DIN_VALID = 1'b1;
            end
            if (pulse && i == 4) DIN_VALID = 1'b0;
            step();
        end
        check($sformatf("idle_xv_%02h", w), lsb ? xv_l : xv_m, 1'b0);
        check($sformatf("idle_x_%02h", w), lsb ? x_l : x_m, 1'b0);
        check($sformatf("idle_done_%02h", w), lsb ? done_l : done_m, 1'b0);
        check($sformatf("idle_rdy_%02h", w), lsb ? rdy_l : rdy_m, 1'b1);
    endtask

    initial begin
        int run;
        logic [15:0] y_exp;
        #2;
        check("rst_rdy", rdy_m, 1'b0);
        check("rst_x", x_m, 1'b0);
        check("rst_xv", xv_m, 1'b0);
        check("rst_done", done_m, 1'b0);
        step();
        nRST = 1'b1;
        step();
        check("post_rst_rdy", rdy_m, 1'b1);

        run_word(8'hB6, 1'b0, 1'b0);
        run_word(8'h01, 1'b1, 1'b0);
        run_word(8'h07, 1'b0, 1'b0);
        run_word(8'h03, 1'b0, 1'b0);
        run_word(8'hB6, 1'b0, 1'b1);

        // Back-to-back E0 then 07 with DIN_VALID held high.
        y_exp = 16'b0010_0000_0000_0001;
        run = 0;
        DIN = 8'hE0;
        DIN_VALID = 1'b1;
        step();
        DIN = 8'h07;
        for (int i = 0; i < 2 * WL; i++) begin
            check($sformatf("b2b_x_%0d", i), x_m,
                  exp_bit((i < WL) ? 8'hE0 : 8'h07, i % WL, 1'b0));
            check($sformatf("b2b_xv_%0d", i), xv_m, 1'b1);
            check($sformatf("b2b_rdy_%0d", i), rdy_m, (i == WL - 1) || (i == 2 * WL - 1));
            run = x_m ? run + 1 : 0;
`ifndef BIT_SERIALIZER_PARITY_EN
            check($sformatf("b2b_y_%0d", i), (run >= 3), y_exp[15-i]);
`endif
            step();
            if (i == WL - 1) DIN_VALID = 1'b0;
        end
        check("b2b_end_xv", xv_m, 1'b0);

        // Reset in the middle of FF.
        DIN = 8'hFF;
        DIN_VALID = 1'b1;
        step();
        DIN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("mid_x_before", x_m, 1'b1);
        nRST = 1'b0;
        #1;
        check("abort_x", x_m, 1'b0);
        check("abort_xv", xv_m, 1'b0);
        check("abort_rdy", rdy_m, 1'b0);
        step();
        nRST = 1'b1;
        #1;
        check("release_rdy", rdy_m, 1'b1);
        for (int i = 0; i < WL; i++) begin
            step();
            check($sformatf("no_residual_xv_%0d", i), xv_m, 1'b0);
            check($sformatf("no_residual_x_%0d", i), x_m, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
